module_gpio_irq_ctrl: RTL

- Edge-event interrupt controller for external input pins.
- Wraps one module_synchronizer instance, drives its `en`, and filters its `rise`/`fall` strobes through per-pin edge-enable masks into a pending register.
- Serialises pending events onto a single irq/irq_id/irq_ack handshake, lowest index first.
- Sits between the GPIO pads and the core's interrupt input; configured over a simple register port.

---
 rtl/module_gpio_irq_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/module_gpio_irq_ctrl.sv
// ----------------------------------------------------------------------------
// module_gpio_irq_ctrl
//
// Edge-event interrupt controller for external GPIO pins. A module_synchronizer
// brings the asynchronous pin levels into the clk domain and produces one-cycle
// rise/fall strobes. Per-pin edge-enable masks filter those strobes into a
// pending register. Pending events are presented one at a time on an
// irq/irq_id/irq_ack handshake, lowest pin index first.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset_n     synchronous active-low reset
//   pins_in     asynchronous pin levels [LEN]
//   ctrl_we     register write strobe
//   ctrl_addr   register select: 0 RISE_EN, 1 FALL_EN, 2 PENDING (W1C),
//               3 write GEN (bit0) / read synchronized pin levels
//   ctrl_wdata  register write data [LEN]
//   ctrl_rdata  combinational read data for ctrl_addr [LEN]
//   irq         interrupt request
//   irq_id      index of the pin being signalled [IDW]
//   irq_ack     one-cycle acknowledge from the core
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// module_synchronizer
//
// STAGES-deep flop chain per bit plus one history flop for edge detection.
// The chain always tracks the pins; en only gates the rise/fall strobes, so
// edges that happen while disabled are dropped instead of being replayed later.
//
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   en            strobe enable
//   data_in       asynchronous input levels [LEN]
//   data_out      synchronized levels [LEN]
//   rise, fall    one-cycle edge strobes [LEN]
// ----------------------------------------------------------------------------
module module_synchronizer #(
    parameter int LEN    = 8,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [LEN-1:0] data_in,
    output logic [LEN-1:0] data_out,
    output logic [LEN-1:0] rise,
    output logic [LEN-1:0] fall
);

    logic [LEN-1:0] sync_q [STAGES];
    logic [LEN-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: this array is a handful of flops, not a RAM, so clearing
            // every entry on reset is cheap and keeps edges deterministic.
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make the chain shift one stage per
            // clock; blocking ones would collapse it into a single flop.
            sync_q[0] <= data_in;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign data_out = sync_q[STAGES-1];
    assign rise     = en ? (data_out & ~prev_q) : '0;
    assign fall     = en ? (~data_out & prev_q) : '0;

endmodule

module module_gpio_irq_ctrl #(
    parameter int LEN    = 8,
    parameter int STAGES = 2,
    parameter int IDW    = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [LEN-1:0] pins_in,
    input  logic           ctrl_we,
    input  logic [1:0]     ctrl_addr,
    input  logic [LEN-1:0] ctrl_wdata,
    output logic [LEN-1:0] ctrl_rdata,
    output logic           irq,
    output logic [IDW-1:0] irq_id,
    input  logic           irq_ack
);

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_RISE_EN = 2'd0;
    localparam logic [1:0] ADDR_FALL_EN = 2'd1;
    localparam logic [1:0] ADDR_PENDING = 2'd2;
    localparam logic [1:0] ADDR_GEN     = 2'd3;

    state_t         state_q, state_next;
    logic [LEN-1:0] rise_en_q, fall_en_q, pending_q, pending_next;
    logic           gen_q;
    logic [IDW-1:0] irq_id_q, lowest_idx;

    logic [LEN-1:0] sync_data, sync_rise, sync_fall;
    logic [LEN-1:0] set_vec, w1c_vec, ack_vec;
    logic           pend_wr, gen_wr, gen_off_wr, w1c_hit;

    module_synchronizer #(
        .LEN    (LEN),
        .STAGES (STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (gen_q),
        .data_in  (pins_in),
        .data_out (sync_data),
        .rise     (sync_rise),
        .fall     (sync_fall)
    );

    // ---------------- register port decode ----------------
    assign pend_wr    = ctrl_we && (ctrl_addr == ADDR_PENDING);
    assign gen_wr     = ctrl_we && (ctrl_addr == ADDR_GEN);
    assign gen_off_wr = gen_wr && !ctrl_wdata[0];
    // A W1C aimed at the bit currently being signalled withdraws the request.
    assign w1c_hit    = pend_wr && ctrl_wdata[irq_id_q];

    always_comb begin
        unique case (ctrl_addr)
            ADDR_RISE_EN: ctrl_rdata = rise_en_q;
            ADDR_FALL_EN: ctrl_rdata = fall_en_q;
            ADDR_PENDING: ctrl_rdata = pending_q;
            default:      ctrl_rdata = sync_data;
        endcase
    end

    // ---------------- pending update ----------------
    // New events are OR-ed in after the clears, so a set always wins over a
    // W1C or ack of the same bit in the same cycle.
    assign set_vec = gen_q ? ((sync_rise & rise_en_q) | (sync_fall & fall_en_q)) : '0;
    assign w1c_vec = pend_wr ? ctrl_wdata : '0;
    assign ack_vec = ((state_q == ASSERT) && irq_ack) ? (LEN'(1) << irq_id_q) : '0;
    assign pending_next = (pending_q & ~(w1c_vec | ack_vec)) | set_vec;

    // Lowest set pending index; scanning downward lets the lowest index win.
    always_comb begin
        // NOTE: default assignment first so no path leaves lowest_idx
        // unassigned, which would otherwise infer a latch.
        lowest_idx = '0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx = IDW'(i);
            end
        end
    end

    // ---------------- configuration and pending registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            gen_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            if (ctrl_we && (ctrl_addr == ADDR_RISE_EN)) rise_en_q <= ctrl_wdata;
            if (ctrl_we && (ctrl_addr == ADDR_FALL_EN)) fall_en_q <= ctrl_wdata;
            if (gen_wr) gen_q <= ctrl_wdata[0];
            pending_q <= pending_next;
            // irq_id is captured once per request and held for its duration.
            if ((state_q == IDLE) && (state_next == ASSERT)) irq_id_q <= lowest_idx;
        end
    end

    // ---------------- handshake FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // ---------------- handshake FSM: next state ----------------
    // ASSERT always returns through IDLE, which guarantees at least one
    // irq-low cycle between consecutive requests.
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            IDLE: begin
                // A simultaneous GEN-off write suppresses a one-cycle stray irq.
                if (gen_q && (|pending_q) && !gen_off_wr) state_next = ASSERT;
            end
            ASSERT: begin
                if (!gen_q || gen_off_wr || irq_ack || w1c_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- handshake FSM: outputs ----------------
    always_comb begin
        irq    = (state_q == ASSERT);
        irq_id = irq_id_q;
    end

endmodule
